// File: rtl/apb_mailbox_slave.sv
// apb_mailbox_slave: APB register map (DATA/STATUS/CTRL) in front of a byte-stream FIFO drained over valid/ready.
// Define APB_MAILBOX_PRIV_CHECK_EN to reject CTRL writes that are not privileged (PPROT[0]=0).
module apb_mailbox_slave #(
   parameter int PADDR_SIZE  = 10,
   parameter int PDATA_SIZE  = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int WAIT_STATES = 1
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic [2:0]              PPROT,
   input  logic                    PWRITE,
   input  logic [PDATA_SIZE/8-1:0] PSTRB,
   input  logic [PADDR_SIZE-1:0]   PADDR,
   input  logic [PDATA_SIZE-1:0]   PWDATA,
   output logic [PDATA_SIZE-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR,
   output logic [PDATA_SIZE-1:0]   pop_data,
   output logic                    pop_valid,
   input  logic                    pop_ready,
   output logic                    irq
);
   localparam int OFS = $clog2(PDATA_SIZE / 8);
   localparam int AW  = $clog2(FIFO_DEPTH);
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t                  state;
   logic [3:0]              wcnt;
   logic [PDATA_SIZE-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]           wptr, rptr;
   logic [AW:0]             count;
   logic                    ovf, irq_en;
   logic [PADDR_SIZE-1:0]   idx;
   logic                    is_data, is_stat, is_ctrl, bad_idx, wr_eff, full, empty, priv_bad;
   logic                    err, commit, push, pop, flush, ovf_set;
   logic [7:0]              status;
   assign idx     = PADDR >> OFS;
   assign is_data = idx == '0;
   assign is_stat = idx == PADDR_SIZE'(1);
   assign is_ctrl = idx == PADDR_SIZE'(2);
   assign bad_idx = idx > PADDR_SIZE'(2);
   assign wr_eff  = PWRITE & |PSTRB;
   assign full    = count == (AW+1)'(FIFO_DEPTH);
   assign empty   = count == '0;
`ifdef APB_MAILBOX_PRIV_CHECK_EN
   logic unused_prot;
   assign unused_prot = ^PPROT[2:1];
   assign priv_bad    = ~PPROT[0];
`else
   logic unused_prot;
   assign unused_prot = ^PPROT;
   assign priv_bad    = 1'b0;
`endif
   assign PREADY  = (state == ACCESS) & PSEL & PENABLE & (wcnt == '0);
   // A zero-strobe write to a valid register is a silent no-op, never an error.
   assign err     = bad_idx | (wr_eff & ((is_data & full) | is_stat | (is_ctrl & priv_bad)));
   assign PSLVERR = PREADY & err;
   assign status  = {4'(count), 1'b0, ovf, full, empty};
   assign PRDATA  = (PREADY & ~PWRITE) ? (is_stat ? PDATA_SIZE'(status) : is_ctrl ? PDATA_SIZE'(irq_en) : '0) : '0;
   assign commit  = PREADY & ~err & wr_eff;
   assign push    = commit & is_data;
   assign flush   = commit & is_ctrl & PWDATA[1];
   assign ovf_set = PREADY & wr_eff & is_data & full;
   assign pop     = ~empty & pop_ready;
   assign pop_valid = ~empty;
   assign pop_data  = empty ? '0 : mem[rptr];
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         state <= IDLE;
         wcnt  <= '0;
      end else if (state == IDLE) begin
         if (PSEL && !PENABLE) begin
            state <= ACCESS;
            wcnt  <= 4'(WAIT_STATES);
         end
      end else if (!PSEL || PREADY) state <= IDLE;
      else if (wcnt != '0) wcnt <= wcnt - 4'd1;
   always_ff @(posedge PCLK)
      if (push) mem[wptr] <= PWDATA;
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
         end
         if (commit && is_ctrl) irq_en <= PWDATA[0];
         if (commit && is_ctrl && PWDATA[2]) ovf <= 1'b0;
         else if (ovf_set) ovf <= 1'b1;
         irq <= irq_en & (ovf | empty);
      end
endmodule

// File: tb/tb_apb_mailbox_slave.sv
// tb_apb_mailbox_slave: scoreboard bench for the APB mailbox with WAIT_STATES=2.
module tb_apb_mailbox_slave;
   localparam int WS = 2;
   logic       PCLK = 0, PRESETn = 0, PSEL = 0, PENABLE = 0, PWRITE = 0, pop_ready = 0;
   logic [2:0] PPROT = 3'b001;
   logic [0:0] PSTRB = 1'b1;
   logic [9:0] PADDR = '0;
   logic [7:0] PWDATA = '0;
   logic [7:0] PRDATA, pop_data;
   logic       PREADY, PSLVERR, pop_valid, irq;
   int         checks = 0, errors = 0;
   logic [8:0] exp_q[$];
   logic [7:0] mq[$];

   apb_mailbox_slave #(.WAIT_STATES(WS)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PPROT(PPROT),
      .PWRITE(PWRITE), .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .pop_data(pop_data), .pop_valid(pop_valid),
      .pop_ready(pop_ready), .irq(irq)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
      end
   endtask

   task automatic apb(input logic w, input logic [9:0] a, input logic [7:0] d, input logic s,
                      input logic [2:0] p, input logic e_err, input logic [7:0] e_rd);
      logic [8:0] e;
      int n;
      exp_q.push_back({e_err, e_rd});
      @(negedge PCLK);
      PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PWDATA = d; PSTRB = s; PPROT = p;
      @(negedge PCLK);
      PENABLE = 1;
      #1;
      n = 0;
      while (!PREADY && n < 20) begin
         @(negedge PCLK);
         #1;
         n++;
      end
      e = exp_q.pop_front();
      check("wait_states", n, WS);
      check("pslverr", PSLVERR, e[8]);
      if (!w) check("prdata", PRDATA, e[7:0]);
      @(posedge PCLK);
      #1;
      if (w && a == 0 && s && !e_err) mq.push_back(d);
      PSEL = 0; PENABLE = 0;
   endtask

   task automatic wr(input logic [9:0] a, input logic [7:0] d, input logic e_err);
      apb(1'b1, a, d, 1'b1, 3'b001, e_err, 8'h00);
   endtask

   task automatic rd(input logic [9:0] a, input logic e_err, input logic [7:0] e_rd);
      apb(1'b0, a, 8'h00, 1'b1, 3'b001, e_err, e_rd);
   endtask

   always @(negedge PCLK) begin
      logic [7:0] hd;
      #3;
      if (pop_valid && pop_ready) begin
         if (mq.size() == 0) check("pop_spurious", pop_valid, 0);
         else begin
            hd = mq.pop_front();
            check("pop_data", pop_data, hd);
         end
      end
   end

   initial begin
      int n;
      #12;
      check("rst_pready", PREADY, 0);
      check("rst_prdata", PRDATA, 0);
      check("rst_pslverr", PSLVERR, 0);
      check("rst_pop_valid", pop_valid, 0);
      check("rst_pop_data", pop_data, 0);
      check("rst_irq", irq, 0);
      @(negedge PCLK);
      PRESETn = 1;
      rd(10'd1, 0, 8'h01);
      wr(10'd0, 8'hA1, 0);
      wr(10'd0, 8'hB2, 0);
      wr(10'd0, 8'hC3, 0);
      wr(10'd0, 8'hD4, 0);
      rd(10'd1, 0, 8'h42);
      wr(10'd0, 8'hE5, 1);
      rd(10'd1, 0, 8'h46);
      check("irq_disabled", irq, 0);
      wr(10'd2, 8'h01, 0);
      check("irq_pre", irq, 0);
      @(posedge PCLK);
      #1;
      check("irq_ovf", irq, 1);
      rd(10'd2, 0, 8'h01);
      wr(10'd2, 8'h05, 0);
      @(posedge PCLK);
      #1;
      check("irq_ovf_clr", irq, 0);
      rd(10'd1, 0, 8'h42);
      @(negedge PCLK);
      pop_ready = 1;
      #1;
      n = 0;
      while (pop_valid && n < 20) begin
         @(negedge PCLK);
         #1;
         n++;
      end
      check("drain_cycles", n, 4);
      check("drain_left", mq.size(), 0);
      @(posedge PCLK);
      #1;
      check("irq_empty", irq, 1);
      rd(10'd3, 1, 8'h00);
      wr(10'd1, 8'hFF, 1);
      rd(10'd5, 1, 8'h00);
      wr(10'd5, 8'h07, 1);
      rd(10'd1, 0, 8'h01);
      rd(10'd2, 0, 8'h01);
      apb(1'b1, 10'd0, 8'h5A, 1'b0, 3'b001, 0, 8'h00);
      rd(10'd1, 0, 8'h01);
      rd(10'd0, 0, 8'h00);
      pop_ready = 0;
      wr(10'd0, 8'h11, 0);
      wr(10'd0, 8'h22, 0);
      rd(10'd1, 0, 8'h20);
      wr(10'd2, 8'h03, 0);
      mq.delete();
      rd(10'd1, 0, 8'h01);
      rd(10'd2, 0, 8'h01);
      wr(10'd0, 8'h33, 0);
      rd(10'd1, 0, 8'h10);
      @(negedge PCLK);
      PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 0; PWDATA = 8'h44; PSTRB = 1;
      @(negedge PCLK);
      PENABLE = 1;
      #1;
      check("abort_pready", PREADY, 0);
      @(negedge PCLK);
      PSEL = 0; PENABLE = 0;
      rd(10'd1, 0, 8'h10);
      wr(10'd0, 8'h55, 0);
      wr(10'd0, 8'h66, 0);
      rd(10'd1, 0, 8'h30);
      @(negedge PCLK);
      PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 0; PWDATA = 8'h77; PSTRB = 1;
      @(negedge PCLK);
      PENABLE = 1;
      @(negedge PCLK);
      PRESETn = 0;
      #1;
      check("rstmid_pop_valid", pop_valid, 0);
      check("rstmid_pready", PREADY, 0);
      mq.delete();
      PSEL = 0; PENABLE = 0;
      @(negedge PCLK);
      PRESETn = 1;
      rd(10'd1, 0, 8'h01);
      rd(10'd2, 0, 8'h00);
`ifdef APB_MAILBOX_PRIV_CHECK_EN
      apb(1'b1, 10'd2, 8'h01, 1'b1, 3'b000, 1, 8'h00);
      rd(10'd2, 0, 8'h00);
      apb(1'b1, 10'd2, 8'h01, 1'b1, 3'b001, 0, 8'h00);
      rd(10'd2, 0, 8'h01);
`else
      apb(1'b1, 10'd2, 8'h01, 1'b1, 3'b000, 0, 8'h00);
      rd(10'd2, 0, 8'h01);
`endif
      pop_ready = 1;
      wr(10'd0, 8'h88, 0);
      wr(10'd0, 8'h99, 0);
      repeat (4) @(posedge PCLK);
      #1;
      check("stream_left", mq.size(), 0);
      check("stream_pop_valid", pop_valid, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end
endmodule
